// File: rtl/gcd_stream_driver.sv
// On-chip requester/checker for the GcdUnit val/rdy interface: streams a loaded
// vector store into the unit, checks results in order, and reports pass/fail.
module gcd_stream_driver #(
    parameter int NUM_VECTORS     = 100,
    parameter int ADDR_WIDTH      = $clog2(NUM_VECTORS),
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [47:0]           load_data,
    output logic [31:0]           req_msg,
    output logic                  req_val,
    input  logic                  req_rdy,
    input  logic [15:0]           resp_msg,
    input  logic                  resp_val,
    output logic                  resp_rdy,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_idx
);

    // Indices must be able to hold NUM_VECTORS itself (the "finished" value).
    localparam int CW = $clog2(NUM_VECTORS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [47:0]       store [NUM_VECTORS];
    logic [CW-1:0]     issue_idx, check_idx;
    logic [3:0]        outstanding;
    logic [WW-1:0]     watchdog;
    logic [ADDR_WIDTH-1:0] issue_addr, check_addr;
    logic              active, idle_like, req_fire, resp_fire, mismatch;
    logic              wd_count, wd_expire;

    assign active     = (state == RUN) || (state == DRAIN);
    assign idle_like  = (state == IDLE) || (state == DONE);
    assign issue_addr = (issue_idx < CW'(NUM_VECTORS)) ? issue_idx[ADDR_WIDTH-1:0] : '0;
    assign check_addr = (check_idx < CW'(NUM_VECTORS)) ? check_idx[ADDR_WIDTH-1:0] : '0;

    // All handshake outputs depend only on registers, so they move on clock edges only.
    assign req_val   = (state == RUN) && (issue_idx < CW'(NUM_VECTORS)) &&
                       (outstanding < 4'(MAX_OUTSTANDING));
    assign req_msg   = store[issue_addr][31:0];
    assign resp_rdy  = active && (outstanding != 4'd0);
    assign req_fire  = req_val & req_rdy;
    assign resp_fire = resp_val & resp_rdy;
    assign mismatch  = resp_msg != store[check_addr][47:32];
    assign wd_count  = resp_rdy && !resp_val;
    assign wd_expire = wd_count && (watchdog == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (wd_expire)
                    state_nxt = DONE;
                else if (req_fire && issue_idx == CW'(NUM_VECTORS - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (wd_expire || check_idx == CW'(NUM_VECTORS))
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            issue_idx     <= '0;
            check_idx     <= '0;
            outstanding   <= '0;
            watchdog      <= '0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            state <= state_nxt;
            if (idle_like && start) begin
                issue_idx     <= '0;
                check_idx     <= '0;
                outstanding   <= '0;
                watchdog      <= '0;
                pass          <= 1'b0;
                timeout       <= 1'b0;
                err_count     <= '0;
                first_err_idx <= '0;
            end else begin
                if (req_fire) issue_idx <= issue_idx + 1'b1;
                if (resp_fire) begin
                    check_idx <= check_idx + 1'b1;
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
                        if (err_count == 16'd0) first_err_idx <= check_addr;
                    end
                end
                case ({req_fire, resp_fire})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: outstanding <= outstanding;
                endcase
                watchdog <= (wd_count && !wd_expire) ? watchdog + 1'b1 : '0;
                if (wd_expire) timeout <= 1'b1;
                // Results are final by the time DONE is entered; timeout entry never passes.
                if (state != DONE && state_nxt == DONE)
                    pass <= (err_count == 16'd0) && !wd_expire;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && idle_like && ({1'b0, load_addr} < (ADDR_WIDTH + 1)'(NUM_VECTORS)))
            store[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_gcd_stream_driver.sv
// Directed bench for gcd_stream_driver with a small GcdUnit stand-in whose
// responses can be withheld, released, or spoofed.
module tb_gcd_stream_driver;

    localparam int NV = 6;
    localparam int AW = $clog2(NV);
    localparam int MO = 4;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          reset, start, load_en, req_rdy, resp_en, junk_val, flush;
    logic [AW-1:0] load_addr;
    logic [47:0]   load_data;
    logic [31:0]   req_msg;
    logic          req_val, resp_val, resp_rdy, busy, done, pass, timeout;
    logic [15:0]   resp_msg, err_count;
    logic [AW-1:0] first_err_idx;

    int checks = 0;
    int errors = 0;

    gcd_stream_driver #(.NUM_VECTORS(NV), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO),
                        .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gcd(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 16'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // GcdUnit stand-in: one queued result per accepted request
    logic [15:0] fifo [16];
    logic [3:0]  wr_ptr = '0, rd_ptr = '0;
    logic [31:0] req_log [256];
    int          req_cnt = 0;

    assign resp_val = junk_val || (resp_en && (wr_ptr != rd_ptr));
    assign resp_msg = junk_val ? 16'hDEAD : fifo[rd_ptr];

    always @(posedge clk) begin
        if (req_val && req_rdy) begin
            req_log[req_cnt[7:0]] <= req_msg;
            req_cnt <= req_cnt + 1;
        end
        if (reset || flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (req_val && req_rdy) begin
                fifo[wr_ptr] <= gcd(req_msg[31:16], req_msg[15:0]);
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resp_val && resp_rdy && !junk_val) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [47:0] vec [NV];

    task automatic load(input int addr, input logic [47:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int base, n;
        vec[0] = {16'd5, 16'd15, 16'd5};
        vec[1] = {16'd7, 16'd21, 16'd14};
        vec[2] = {16'd1, 16'd17, 16'd13};
        vec[3] = {16'd9, 16'd0,  16'd9};
        vec[4] = {16'd6, 16'd48, 16'd18};
        vec[5] = {16'd7, 16'd7,  16'd0};
        reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        req_rdy = 1'b0; resp_en = 1'b0; junk_val = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_val", {31'd0, req_val}, 0);
        chk("rst_resp_rdy", {31'd0, resp_rdy}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_err", {16'd0, err_count}, 0);
        chk("rst_first", 32'(first_err_idx), 0);
        reset = 1'b0;
        for (int i = 0; i < NV; i++) load(i, vec[i]);

        // Clean run with a correct responder
        req_rdy = 1'b1; resp_en = 1'b1; base = req_cnt;
        pulse_start();
        chk("lat_req_val", {31'd0, req_val}, 1);
        chk("lat_req_msg", req_msg, vec[0][31:0]);
        chk("run_busy", {31'd0, busy}, 1);
        wait_done("t1");
        chk("t1_pass", {31'd0, pass}, 1);
        chk("t1_err", {16'd0, err_count}, 0);
        chk("t1_timeout", {31'd0, timeout}, 0);
        chk("t1_count", req_cnt - base, NV);
        for (int i = 0; i < NV; i++) chk("t1_order", req_log[8'(base + i)], vec[i][31:0]);

        // One wrong expectation at index 2
        load(2, {16'd3, vec[2][31:0]});
        pulse_start();
        wait_done("t2");
        chk("t2_pass", {31'd0, pass}, 0);
        chk("t2_err", {16'd0, err_count}, 1);
        chk("t2_first", 32'(first_err_idx), 2);
        load(2, vec[2]);

        // Outstanding limit with withheld responses; no bubbles on issue
        resp_en = 1'b0; base = req_cnt;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("lim_count4", req_cnt - base, MO);
        chk("lim_req_val", {31'd0, req_val}, 0);
        repeat (5) @(negedge clk);
        chk("lim_hold", req_cnt - base, MO);
        chk("lim_resp_rdy", {31'd0, resp_rdy}, 1);
        resp_en = 1'b1;
        @(negedge clk);
        resp_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("lim_one_more", req_cnt - base, MO + 1);
        chk("lim_req_val2", {31'd0, req_val}, 0);
        resp_en = 1'b1;
        wait_done("t3");
        chk("t3_pass", {31'd0, pass}, 1);
        chk("t3_count", req_cnt - base, NV);

        // Simultaneous request and response fire with two outstanding
        resp_en = 1'b0; base = req_cnt;
        pulse_start();
        repeat (2) @(negedge clk);
        req_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("dual_pre", req_cnt - base, 2);
        req_rdy = 1'b1; resp_en = 1'b1;
        @(negedge clk);
        resp_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("dual_count", req_cnt - base, 5);
        chk("dual_req_val", {31'd0, req_val}, 0);
        resp_en = 1'b1;
        wait_done("t4");
        chk("t4_pass", {31'd0, pass}, 1);

        // Response offered with nothing outstanding is refused and not compared
        req_rdy = 1'b0; resp_en = 1'b0;
        pulse_start();
        junk_val = 1'b1;
        @(negedge clk);
        chk("junk_resp_rdy", {31'd0, resp_rdy}, 0);
        chk("junk_busy", {31'd0, busy}, 1);
        @(negedge clk);
        junk_val = 1'b0; req_rdy = 1'b1; resp_en = 1'b1;
        wait_done("t5");
        chk("t5_err", {16'd0, err_count}, 0);
        chk("t5_pass", {31'd0, pass}, 1);

        // Watchdog: no responses ever
        resp_en = 1'b0;
        pulse_start();
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO + 1);
        chk("to_timeout", {31'd0, timeout}, 1);
        chk("to_pass", {31'd0, pass}, 0);
        chk("to_req_val", {31'd0, req_val}, 0);
        chk("to_resp_rdy", {31'd0, resp_rdy}, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_hold", {30'd0, done, timeout}, 3);

        // Reset mid-run, write attempt in RUN, rerun from index 0
        pulse_start();
        repeat (2) @(negedge clk);
        reset = 1'b1; flush = 1'b1;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_done", {31'd0, done}, 0);
        chk("mr_req_val", {31'd0, req_val}, 0);
        chk("mr_timeout", {31'd0, timeout}, 0);
        req_rdy = 1'b0; resp_en = 1'b1;
        pulse_start();
        load(0, {16'h0000, 32'hFFFF_FFFF});
        chk("mr_run_busy", {31'd0, busy}, 1);
        base = req_cnt; req_rdy = 1'b1;
        wait_done("t7");
        chk("t7_pass", {31'd0, pass}, 1);
        chk("t7_err", {16'd0, err_count}, 0);
        chk("t7_first_req", req_log[8'(base)], vec[0][31:0]);
        chk("t7_count", req_cnt - base, NV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
